led_pattern_top: RTL and testbench

//   Board-level top for the LED demo. Drives three LEDs with a prescaled pattern.
//   A debounced push button (active-low) switches between two patterns:

---
 rtl/led_pattern_top.sv | 100 ++++++++++
 tb/tb_led_pattern_top.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_top.sv
// Three-LED pattern generator: binary count or one-hot rotate, stepped by a prescaler,
// with a debounced active-low push button that toggles between the two patterns.
module led_pattern_top #(
   parameter int PRESCALE = 100,
   parameter int DEBOUNCE = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   output logic led0,
   output logic led1,
   output logic led2
);

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    pat_q, pat_d;
   logic          mode_q, mode_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          btn_db_q, btn_db_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_s;
   logic          press_s;

   // Button synchronizer and debouncer; a press is the same-edge fall of the debounced level.
   always_comb begin
      sync1_d  = button;
      sync2_d  = sync1_q;
      btn_db_d = btn_db_q;
      cnt_d    = '0;
      if (sync2_q != btn_db_q) begin
         if (cnt_q == DB_LAST) begin
            btn_db_d = sync2_q;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
      end
      press_s = btn_db_q & ~btn_db_d;
   end

   // Prescaler, mode toggle and pattern stepping; a press overrides a coincident tick.
   always_comb begin
      tick_s  = (presc_q == PRESC_LAST);
      presc_d = tick_s ? '0 : presc_q + PW'(1);
      mode_d  = mode_q;
      pat_d   = pat_q;
      if (press_s) begin
         mode_d  = ~mode_q;
         pat_d   = 3'b000;
         presc_d = '0;
      end else if (tick_s) begin
         if (!mode_q) begin
            pat_d = pat_q + 3'd1;
         end else begin
            case (pat_q)
               3'b001:  pat_d = 3'b010;
               3'b010:  pat_d = 3'b100;
               3'b100:  pat_d = 3'b001;
               default: pat_d = 3'b001;
            endcase
         end
      end else begin
         pat_d = pat_q;
      end
   end

   // State registers; synchronizer and debounced level idle at the released level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q  <= '0;
         pat_q    <= 3'b000;
         mode_q   <= 1'b0;
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         btn_db_q <= 1'b1;
         cnt_q    <= '0;
      end else begin
         presc_q  <= presc_d;
         pat_q    <= pat_d;
         mode_q   <= mode_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         btn_db_q <= btn_db_d;
         cnt_q    <= cnt_d;
      end
   end

   assign led0 = pat_q[0];
   assign led1 = pat_q[1];
   assign led2 = pat_q[2];

endmodule

// File: tb/tb_led_pattern_top.sv
// Bench for led_pattern_top: directed scenarios plus random button activity, checked
// every cycle against a step-count model of the LED pattern.
module tb_led_pattern_top;

   localparam int PRESCALE = 100;
   localparam int DEBOUNCE = 16;

   logic clk = 1'b0;
   logic reset;
   logic button;
   logic led0, led1, led2;
   logic [2:0] leds;

   int checks   = 0;
   int failures = 0;

   // model state: pattern is a function of mode and the number of ticks since the last press/reset
   int m_mode, m_steps, m_ph, m_run;
   logic m_s1, m_s2, m_db;

   // change capture
   logic [2:0] cap_val[$];
   int         cap_cyc[$];

   led_pattern_top #(.PRESCALE(PRESCALE), .DEBOUNCE(DEBOUNCE)) dut (
      .clk    (clk),
      .reset  (reset),
      .button (button),
      .led0   (led0),
      .led1   (led1),
      .led2   (led2)
   );

   always #50 clk = ~clk;
   assign leds = {led2, led1, led0};

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_pat();
      if (m_mode == 0) return 3'(m_steps % 8);
      if (m_steps == 0) return 3'b000;
      return 3'(1 << ((m_steps - 1) % 3));
   endfunction

   task automatic model_reset();
      m_mode = 0; m_steps = 0; m_ph = 0; m_run = 0;
      m_s1 = 1'b1; m_s2 = 1'b1; m_db = 1'b1;
   endtask

   task automatic model_step(input logic b);
      logic old_s2, new_db, press;
      old_s2 = m_s2;
      m_s2   = m_s1;
      m_s1   = b;
      new_db = m_db;
      if (old_s2 != m_db) begin
         m_run++;
         if (m_run == DEBOUNCE) begin
            new_db = old_s2;
            m_run  = 0;
         end
      end else begin
         m_run = 0;
      end
      press = m_db && !new_db;
      m_db  = new_db;
      if (press) begin
         m_mode  = 1 - m_mode;
         m_steps = 0;
         m_ph    = 0;
      end else if (m_ph == PRESCALE - 1) begin
         m_steps++;
         m_ph = 0;
      end else begin
         m_ph++;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(button);
      @(negedge clk);
      check("model", leds, exp_pat());
   endtask

   task automatic run_capture(input int n);
      logic [2:0] prev;
      cap_val.delete();
      cap_cyc.delete();
      prev = leds;
      for (int k = 1; k <= n; k++) begin
         cycle();
         if (leds !== prev) begin
            cap_val.push_back(leds);
            cap_cyc.push_back(k);
            prev = leds;
         end
      end
   endtask

   initial begin
      int left, len;
      logic [2:0] exp_seq[4];
      reset  = 1'b1;
      button = 1'b1;
      model_reset();

      // 1. reset values regardless of button
      for (int k = 0; k < 4; k++) begin
         button = 1'(k);
         @(negedge clk);
         check("reset_leds", leds, 3'b000);
      end
      button = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // 2. binary count with button released
      for (int i = 1; i <= 2000; i++) begin
         cycle();
         if (i == 99)   check("led0_before_100", leds, 3'b000);
         if (i == 100)  check("led0_rise_100", leds, 3'b001);
         if (i == 200)  check("led1_rise_200", leds, 3'b010);
         if (i == 399)  check("before_400", leds, 3'b011);
         if (i == 400)  check("led2_rise_400", leds, 3'b100);
         if (i == 1900) check("edge_1900", leds, 3'b011);
      end

      // 3. glitch shorter than the debounce window
      button = 1'b0;
      repeat (10) cycle();
      button = 1'b1;
      repeat (120) cycle();
      check_int("glitch_mode", m_mode, 0);
      check("glitch_count", leds, 3'b101);

      // 4. press into rotate mode
      button = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         cycle();
         if (k == DEBOUNCE + 4) check("press_clear", leds, 3'b000);
         if (k == 40) button = 1'b1;
      end
      run_capture(400);
      exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
      check_int("rotate_changes", cap_val.size(), 4);
      for (int k = 0; k < 4 && k < cap_val.size(); k++) begin
         check("rotate_seq", cap_val[k], exp_seq[k]);
         if (k > 0) check_int("rotate_spacing", cap_cyc[k] - cap_cyc[k-1], PRESCALE);
      end

      // 5. second press back to binary; release changes nothing
      button = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         cycle();
         if (k == DEBOUNCE + 4) check("press2_clear", leds, 3'b000);
      end
      button = 1'b1;
      run_capture(300);
      exp_seq = '{3'b001, 3'b010, 3'b011, 3'b000};
      check_int("binary_changes", cap_val.size(), 3);
      for (int k = 0; k < 3 && k < cap_val.size(); k++)
         check("binary_seq", cap_val[k], exp_seq[k]);

      // 6. async reset at pattern 101
      len = 0;
      while (leds !== 3'b101 && len < 300) begin
         cycle();
         len++;
      end
      check("reach_101", leds, 3'b101);
      #10;
      reset = 1'b1;
      #1;
      check("async_reset", leds, 3'b000);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         cycle();
         if (i == 99)  check("rst_before_100", leds, 3'b000);
         if (i == 100) check("rst_first_inc", leds, 3'b001);
      end
      check_int("rst_mode", m_mode, 0);

      // random button activity
      left = 4000;
      while (left > 0) begin
         len    = $urandom_range(1, 40);
         button = 1'($urandom_range(0, 1));
         repeat (len) cycle();
         left -= len;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
